// File: rtl/req_sched_pkg.sv
// Shared types and constants for the request/phase scheduler and its helpers.
package req_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARB     = 2'd1,
      GRANT   = 2'd2,
      RELEASE = 2'd3
   } sched_state_t;

   localparam int         DEF_NUM_REQ  = 7;
   localparam int         DEF_PHASES   = 4;
   localparam int         DEF_HOLD_MAX = 3;
   localparam int         DEF_CNT_W    = 2;
   localparam logic [3:0] PHASE_RESET  = 4'b0001;

   // Modular step used by the round-robin search; base is always below n.
   function automatic int wrap_add(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/req_phase_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request after last_ptr, wrapping.
module rr_pick
   import req_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   index,
   output logic               any
);

   logic [IDX_W-1:0] cand_s;
   logic             hit_s;

   // Walk offsets 1..NUM_REQ; the first hit latches and later hits are masked by any.
   always_comb begin
      onehot = '0;
      index  = '0;
      any    = 1'b0;
      cand_s = '0;
      hit_s  = 1'b0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand_s         = IDX_W'(wrap_add(int'(last_ptr), off, NUM_REQ));
         hit_s          = req[cand_s] & ~any;
         onehot[cand_s] = hit_s;
         index          = hit_s ? cand_s : index;
         any            = any | req[cand_s];
      end
   end

endmodule

// File: rtl/req_phase_scheduler.sv
// Command-slot scheduler: phase ring, round-robin arbitration and grant hold with timeout.
module req_phase_scheduler
   import req_sched_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int PHASES   = DEF_PHASES,
   parameter int HOLD_MAX = DEF_HOLD_MAX,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   input  logic               ack,
   output logic [PHASES-1:0]  phase,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   output logic               busy,
   output logic               idle_req,
   output logic               timeout
);

   localparam int                IDX_W    = $clog2(NUM_REQ);
   localparam logic [PHASES-1:0] PH_INIT  = PHASES'(PHASE_RESET);
   localparam logic [IDX_W-1:0]  PTR_INIT = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0]  HOLD_END = CNT_W'(HOLD_MAX - 1);

   sched_state_t       state_r;
   logic [CNT_W-1:0]   hold_cnt_r;
   logic [IDX_W-1:0]   last_ptr_r;
   logic [NUM_REQ-1:0] pick_onehot_s;
   logic [IDX_W-1:0]   pick_index_s;
   logic               pick_any_s;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req      (req),
      .last_ptr (last_ptr_r),
      .onehot   (pick_onehot_s),
      .index    (pick_index_s),
      .any      (pick_any_s)
   );

   // Scheduler FSM with phase ring, hold counter and every output registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         hold_cnt_r  <= '0;
         last_ptr_r  <= PTR_INIT;
         phase       <= PH_INIT;
         grant       <= '0;
         grant_valid <= 1'b0;
         busy        <= 1'b0;
         idle_req    <= 1'b1;
         timeout     <= 1'b0;
      end else begin
         idle_req <= ~|req;
         timeout  <= 1'b0;
         if (en) begin
            phase <= {phase[PHASES-2:0], phase[PHASES-1]};
         end else begin
            phase <= phase;
         end

         case (state_r)
            IDLE: begin
               if (en && phase[0] && |req) begin
                  state_r <= ARB;
                  busy    <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
            end

            // Requests may have dropped since entry; an empty pick aborts quietly.
            ARB: begin
               if (pick_any_s) begin
                  grant       <= pick_onehot_s;
                  grant_valid <= 1'b1;
                  last_ptr_r  <= pick_index_s;
                  hold_cnt_r  <= '0;
                  state_r     <= GRANT;
               end else begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
            end

            GRANT: begin
               hold_cnt_r <= hold_cnt_r + CNT_W'(1);
               if (ack) begin
                  grant       <= '0;
                  grant_valid <= 1'b0;
                  state_r     <= RELEASE;
               end else if (hold_cnt_r == HOLD_END) begin
                  grant       <= '0;
                  grant_valid <= 1'b0;
                  timeout     <= 1'b1;
                  state_r     <= RELEASE;
               end else begin
                  state_r <= GRANT;
               end
            end

            RELEASE: begin
               hold_cnt_r <= '0;
               busy       <= 1'b0;
               state_r    <= IDLE;
            end

            default: begin
               grant       <= '0;
               grant_valid <= 1'b0;
               busy        <= 1'b0;
               hold_cnt_r  <= '0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/req_phase_scheduler.md
Name: req_phase_scheduler

Overview:
- Sequential controller that schedules the shared command slot of the phase/request decode datapath.
- Generates the 4-phase one-hot strobe, arbitrates 7 requesters round-robin, and holds a one-hot grant until the datapath acknowledges or a hold timeout expires.
- Registered outputs drive the decode logic directly.

Parameters:
- NUM_REQ, 7, number of requesters (one-hot request/grant width).
- PHASES, 4, number of one-hot phase strobes.
- HOLD_MAX, 3, maximum GRANT cycles before forced release (≥1).
- CNT_W, 2, width of hold counter; must satisfy 2^CNT_W ≥ HOLD_MAX.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  phase advance enable.
- req  input  NUM_REQ  request lines; bit i = requester i.
- ack  input  1  datapath transfer-complete strobe.
- phase  output  PHASES  one-hot phase strobe.
- grant  output  NUM_REQ  one-hot grant; all-zero when no grant.
- grant_valid  output  1  high exactly when grant is non-zero.
- busy  output  1  FSM not in IDLE.
- idle_req  output  1  registered NOR of req.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: phase = 0001, grant = 0, grant_valid = 0, busy = 0, idle_req = 1, timeout = 0, state = IDLE, hold_cnt = 0, last_ptr = NUM_REQ-1, so the first search starts at requester 0.
- Reset mid-operation: reset asserted in any state clears everything to the reset values immediately. No grant survives reset.
- Phase rotation:
  - When en = 1, phase rotates left each cycle: 0001→0010→0100→1000→0001.
  - When en = 0, phase holds.
  - Phase never becomes zero or multi-hot.
- idle_req: registered each cycle as ~|req.
- FSM states: IDLE, ARB, GRANT, RELEASE.
  - IDLE→ARB when en & phase[0] & |req. Otherwise stay in IDLE.
  - ARB, one cycle:
    - Winner = first set req bit searching last_ptr+1, last_ptr+2, … modulo NUM_REQ.
    - If req is now zero, return to IDLE with no grant.
    - Otherwise register grant = onehot(winner), last_ptr = winner, hold_cnt = 0, and go to GRANT.
    - Latency from the qualifying IDLE cycle to grant visible is 2 cycles.
  - GRANT:
    - grant is held constant; there is no preemption, even if the granted req drops.
    - hold_cnt increments each cycle.
    - ack = 1 → RELEASE, no timeout.
    - ack = 0 and hold_cnt = HOLD_MAX-1 → RELEASE, timeout = 1 for that transition cycle only.
    - ack and the timeout condition in the same cycle → ack wins, timeout = 0.
  - RELEASE, one cycle: grant = 0, then IDLE.
    - ack seen in RELEASE or IDLE is ignored.
- en affects only phase rotation and the IDLE→ARB entry. ARB, GRANT and RELEASE proceed regardless of en.
- Wrap-around: when last_ptr = NUM_REQ-1, the search starts at 0. A single persistent requester is re-granted every arbitration round.
- grant_valid = |grant. busy = (state ≠ IDLE).
- All outputs are registered; no combinational path from input to output.

Decomposition:
- Shared package req_sched_pkg:
  - state enum {IDLE, ARB, GRANT, RELEASE}, 2-bit encoding.
  - Constants PHASE_RESET = 0001 and default NUM_REQ / HOLD_MAX.
- One natural sub-module, rr_pick: combinational round-robin priority picker (req, last_ptr → onehot winner, index, any). It is reusable by other schedulers.
- Top module: FSM, phase ring, hold counter, output registers.

Test Plan:
- Reset/phase:
  - Assert rst mid-GRANT → grant = 0, phase = 0001, busy = 0 immediately, without waiting for a clock edge.
  - en = 1 for 5 cycles → phase 0010, 0100, 1000, 0001, 0010.
- Single request: req = 0000100 at phase 0001, en = 1, ack asserted 1 cycle after grant → grant = 0000100 two cycles later, released next cycle, timeout = 0.
- Round-robin wrap: req = 1000001 held, ack each grant → grants alternate 0000001, 1000000, 0000001. Then with last_ptr = 6 and req = 1111111, next grant = 0000001.
- Timeout: grant issued, ack held 0 → after HOLD_MAX = 3 GRANT cycles, timeout pulses once, grant → 0, FSM returns to IDLE.
- Simultaneous and en edge cases:
  - ack on the final hold cycle → no timeout pulse.
  - Requester drops req during ARB with req now all-zero → no grant, return to IDLE.
  - en = 0 with req = 0000001 → phase frozen, no arbitration entry; GRANT in progress still completes on ack.
